rbm_argmax_classifier: RTL and testbench

//  Downstream stage of the two-layer RBM top. Consumes the per-class accumulated scores the top

---
 rtl/rbm_argmax_classifier_pkg.sv | 12 +
 rtl/rbm_argmax_classifier_signed_max_cell.sv | 32 +++
 rtl/rbm_argmax_classifier.sv | 130 +++++++++++++
 tb/tb_rbm_argmax_classifier.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rbm_argmax_classifier_pkg.sv
// Shared definitions for the RBM argmax classifier.
//   state_t : scan controller states. The encodings are fixed because the
//             state is visible to debug logic in the surrounding RBM top.
package rbm_argmax_classifier_pkg;

  typedef enum logic [1:0] {
    state_idle = 2'd0,
    state_scan = 2'd1,
    state_done = 2'd2
  } state_t;

endpackage

// File: rtl/rbm_argmax_classifier_signed_max_cell.sv
// rbm_signed_max_cell
// Purpose: the single comparator of the classifier. It compares a candidate
// score against the current best score as two's complement values. On a tie
// the incumbent is kept, so the lowest index wins the scan.
// Ports:
//   cand_val  in   bitlength    candidate score (signed)
//   cand_idx  in   index_width  candidate class index
//   best_val  in   bitlength    current best score (signed)
//   best_idx  in   index_width  current best class index
//   greater   out  1            candidate strictly greater than best
//   sel_val   out  bitlength    winner of the pair
//   sel_idx   out  index_width  index of the winner
module rbm_signed_max_cell #(
  parameter int bitlength   = 12,
  parameter int index_width = 4
) (
  input  logic signed [bitlength-1:0]   cand_val,
  input  logic        [index_width-1:0] cand_idx,
  input  logic signed [bitlength-1:0]   best_val,
  input  logic        [index_width-1:0] best_idx,
  output logic                          greater,
  output logic signed [bitlength-1:0]   sel_val,
  output logic        [index_width-1:0] sel_idx
);

  always_comb begin
    greater = (cand_val > best_val);
    sel_val = greater ? cand_val : best_val;
    sel_idx = greater ? cand_idx : best_idx;
  end

endmodule

// File: rtl/rbm_argmax_classifier.sv
// rbm_argmax_classifier
// Purpose: downstream stage of the two-layer RBM top. On the rising edge of
// score_done it snapshots the per-class score vector, scans it one class per
// clock through a single signed comparator, and presents the winning class
// index and score over a valid/ready handshake.
// Ports:
//   clock         in   1                      clock, all state on posedge
//   reset         in   1                      asynchronous, active-high
//   score_done    in   1                      level "scores final" flag
//   Scores        in   output_dim*bitlength   packed signed scores, element g at [g*bitlength +: bitlength]
//   class_index   out  index_width            winning class
//   class_score   out  bitlength              signed score of winning class
//   result_valid  out  1                      result held stable while high
//   result_ready  in   1                      result accepted on valid && ready
//   busy          out  1                      high while scanning
module rbm_argmax_classifier
  import rbm_argmax_classifier_pkg::*;
#(
  parameter int bitlength   = 12,
  parameter int output_dim  = 10,
  parameter int index_width = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             score_done,
  input  logic [output_dim*bitlength-1:0]  Scores,
  output logic [index_width-1:0]           class_index,
  output logic signed [bitlength-1:0]      class_score,
  output logic                             result_valid,
  input  logic                             result_ready,
  output logic                             busy
);

  localparam logic [index_width-1:0] last_index = index_width'(output_dim - 1);

  state_t                           state;
  logic [output_dim*bitlength-1:0]  snapshot;
  logic [index_width-1:0]           counter;
  logic [index_width-1:0]           best_idx;
  logic signed [bitlength-1:0]      best_val;
  logic signed [bitlength-1:0]      cand_val;
  logic                             score_done_q;
  logic                             start;
  logic                             greater;
  logic signed [bitlength-1:0]      sel_val;
  logic [index_width-1:0]           sel_idx;

  // The history flop resets to 1 so a flag already high when reset is
  // released is not mistaken for a fresh start.
  assign start    = score_done && !score_done_q;
  assign cand_val = snapshot[counter*bitlength +: bitlength];

  rbm_signed_max_cell #(
    .bitlength   (bitlength),
    .index_width (index_width)
  ) u_max_cell (
    .cand_val (cand_val),
    .cand_idx (counter),
    .best_val (best_val),
    .best_idx (best_idx),
    .greater  (greater),
    .sel_val  (sel_val),
    .sel_idx  (sel_idx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= state_idle;
      snapshot     <= '0;
      counter      <= '0;
      best_idx     <= '0;
      best_val     <= '0;
      score_done_q <= 1'b1;
      class_index  <= '0;
      class_score  <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      score_done_q <= score_done;
      case (state)
        state_idle: begin
          if (start) begin
            // Scan works from a private copy so the top may keep updating
            // Scores without disturbing the result.
            snapshot <= Scores;
            best_idx <= '0;
            best_val <= Scores[bitlength-1:0];
            counter  <= index_width'(1);
            if (output_dim == 1) begin
              class_index  <= '0;
              class_score  <= Scores[bitlength-1:0];
              result_valid <= 1'b1;
              state        <= state_done;
            end else begin
              busy  <= 1'b1;
              state <= state_scan;
            end
          end
        end
        state_scan: begin
          if (greater) begin
            best_idx <= sel_idx;
            best_val <= sel_val;
          end
          counter <= counter + 1'b1;
          if (counter == last_index) begin
            // sel_* already folds in the last element, so it is the final winner.
            class_index  <= sel_idx;
            class_score  <= sel_val;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= state_done;
          end
        end
        state_done: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= state_idle;
          end
        end
        default: begin
          busy         <= 1'b0;
          result_valid <= 1'b0;
          state        <= state_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rbm_argmax_classifier.sv
module tb_rbm_argmax_classifier;

  localparam int bitlength   = 12;
  localparam int output_dim  = 10;
  localparam int index_width = 4;

  logic                            clock;
  logic                            reset;
  logic                            score_done;
  logic [output_dim*bitlength-1:0] Scores;
  logic [index_width-1:0]          class_index;
  logic signed [bitlength-1:0]     class_score;
  logic                            result_valid;
  logic                            result_ready;
  logic                            busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int sc[output_dim];
    int exp_idx;
    int exp_score;
  } vec_t;

  vec_t vecs[7];

  rbm_argmax_classifier #(
    .bitlength   (bitlength),
    .output_dim  (output_dim),
    .index_width (index_width)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .score_done   (score_done),
    .Scores       (Scores),
    .class_index  (class_index),
    .class_score  (class_score),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int sc[output_dim]);
    for (int g = 0; g < output_dim; g++)
      Scores[g*bitlength +: bitlength] = bitlength'(sc[g]);
  endtask

  // Raise score_done (already loaded Scores) and wait for result_valid.
  // Returns number of clocks from the edge until valid was seen.
  task automatic start_and_wait(output int lat);
    lat = 0;
    score_done = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 1) chk("busy_in_scan", busy, 1);
      if (result_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_vector(input int k);
    int lat;
    load(vecs[k].sc);
    start_and_wait(lat);
    chk($sformatf("latency_v%0d", k), lat, output_dim);
    chk($sformatf("index_v%0d", k), int'(class_index), vecs[k].exp_idx);
    chk($sformatf("score_v%0d", k), int'(class_score), vecs[k].exp_score);
    chk($sformatf("busy_done_v%0d", k), busy, 0);
    result_ready = 1'b1;
    tick();
    chk($sformatf("valid_drop_v%0d", k), result_valid, 0);
    chk($sformatf("index_keep_v%0d", k), int'(class_index), vecs[k].exp_idx);
    result_ready = 1'b0;
    score_done   = 1'b0;
    tick();
  endtask

  initial begin
    int lat;
    int sc_a[output_dim];
    int sc_b[output_dim];
    logic seen;

    vecs[0].sc = '{0, 5, 3, 9, 1, 2, 0, 0, 0, 4};
    vecs[0].exp_idx = 3;  vecs[0].exp_score = 9;
    vecs[1].sc = '{0, 0, 2047, 0, 0, 0, 0, 2047, 0, 0};
    vecs[1].exp_idx = 2;  vecs[1].exp_score = 2047;
    vecs[2].sc = '{-5, -1, -8, -3, -4, -7, -1, -9, -2, -6};
    vecs[2].exp_idx = 1;  vecs[2].exp_score = -1;
    vecs[3].sc = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
    vecs[3].exp_idx = 0;  vecs[3].exp_score = 7;
    vecs[4].sc = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    vecs[4].exp_idx = 9;  vecs[4].exp_score = 10;
    vecs[5].sc = '{-1, 1, -2048, 0, -3, 0, 1, -7, 0, 0};
    vecs[5].exp_idx = 1;  vecs[5].exp_score = 1;
    vecs[6].sc = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2047};
    vecs[6].exp_idx = 9;  vecs[6].exp_score = -2047;

    reset        = 1'b1;
    score_done   = 1'b0;
    result_ready = 1'b0;
    Scores       = '0;
    tick();
    tick();
    chk("rst_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_index", int'(class_index), 0);
    chk("rst_score", int'(class_score), 0);
    reset = 1'b0;
    tick();

    for (int k = 0; k < 7; k++) run_vector(k);

    // Result held under backpressure; edges and Scores changes in DONE ignored.
    load(vecs[0].sc);
    start_and_wait(lat);
    chk("bp_latency", lat, output_dim);
    for (int c = 0; c < 20; c++) begin
      Scores     = {$urandom, $urandom, $urandom, $urandom};
      score_done = c[0];
      tick();
      chk("bp_valid", result_valid, 1);
      chk("bp_index", int'(class_index), 3);
      chk("bp_score", int'(class_score), 9);
    end
    score_done   = 1'b0;
    result_ready = 1'b1;
    tick();
    chk("bp_valid_drop", result_valid, 0);
    result_ready = 1'b0;
    tick();
    chk("bp_no_restart", busy, 0);
    chk("bp_index_keep", int'(class_index), 3);

    // Snapshot isolation: Scores churns every cycle during SCAN.
    sc_a = '{3, -4, 11, 0, 11, 2, 6, -1, 10, 5};
    load(sc_a);
    score_done = 1'b1;
    lat  = 0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (result_valid) begin
        lat = n;
        break;
      end
      for (int g = 0; g < output_dim; g++) sc_b[g] = 2047;
      sc_b[n % output_dim] = $urandom_range(0, 2047);
      load(sc_b);
    end
    chk("snap_latency", lat, output_dim);
    chk("snap_index", int'(class_index), 2);
    chk("snap_score", int'(class_score), 11);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    score_done   = 1'b0;
    tick();

    // Reset mid-scan with score_done still high: no restart until a new edge.
    load(vecs[0].sc);
    score_done = 1'b1;
    for (int n = 0; n < 4; n++) tick();
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", result_valid, 0);
    chk("mid_rst_index", int'(class_index), 0);
    chk("mid_rst_score", int'(class_score), 0);
    tick();
    reset = 1'b0;
    seen  = 1'b0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (busy || result_valid) seen = 1'b1;
    end
    chk("mid_no_restart", seen, 0);
    score_done = 1'b0;
    tick();
    run_vector(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
